judge_unit: RTL and testbench

- Final-decision stage of the inference pipeline. It runs while the master sequencer sits in its JUDGE state.
- It collects the two class scores from the FC stage (background and human) and decides whether the current frame contains a person on the track.
- It tracks consecutive-detection history and drives the rail alarm.
- It returns Judge_done (more frames remain in the run) or Judge_all_done (run complete) to the master sequencer.

---
 rtl/judge_unit.sv | 91 +++++++++
 tb/tb_judge_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/judge_unit.sv
// judge_unit: final per-frame human/background decision with detection-history alarm and run sequencing
module judge_unit #(
  parameter int STATE_DATAWIDTH = 4,
  parameter int JUDGE_STATE = 12,
  parameter int SCORE_WIDTH = 16,
  parameter logic signed [SCORE_WIDTH-1:0] MARGIN = '0,
  parameter int FRAMES_PER_RUN = 8,
  parameter int ALARM_THRESHOLD = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic [STATE_DATAWIDTH-1:0] state,
  input  logic fc_valid,
  input  logic fc_class_idx,
  input  logic [SCORE_WIDTH-1:0] fc_score,
  output logic Judge_done,
  output logic Judge_all_done,
  output logic human_detected,
  output logic alarm,
  output logic [7:0] frame_count,
  output logic [3:0] consec_count
);
  typedef enum logic [2:0] {J_IDLE, J_COLLECT, J_DECIDE, J_DONE, J_WAIT} jstate_t;
  jstate_t st, nx;
  logic [SCORE_WIDTH-1:0] score_bg, score_h;
  logic seen_bg, seen_h;
  logic in_judge, beat, seen_bg_n, seen_h_n, verdict, last;
  logic signed [SCORE_WIDTH+1:0] h_ext, bg_ext, m_ext;
  logic [3:0] consec_n;
  assign in_judge = state == STATE_DATAWIDTH'(JUDGE_STATE);
  assign beat = st == J_COLLECT && in_judge && fc_valid;
  assign seen_bg_n = seen_bg | (beat & ~fc_class_idx);
  assign seen_h_n = seen_h | (beat & fc_class_idx);
  // Two guard bits keep bg + MARGIN exact for any pair of signed operands
  assign h_ext = {{2{score_h[SCORE_WIDTH-1]}}, score_h};
  assign bg_ext = {{2{score_bg[SCORE_WIDTH-1]}}, score_bg};
  assign m_ext = {{2{MARGIN[SCORE_WIDTH-1]}}, MARGIN};
  assign verdict = h_ext > bg_ext + m_ext;
  assign consec_n = verdict ? (consec_count == 4'd15 ? 4'd15 : consec_count + 4'd1) : 4'd0;
  assign last = frame_count == 8'(FRAMES_PER_RUN - 1);
  always_ff @(posedge clk)
    st <= !reset ? J_IDLE : nx;
  always_comb begin
    nx = st;
    case (st)
      J_IDLE:    nx = in_judge ? J_COLLECT : J_IDLE;
      J_COLLECT: nx = !in_judge ? J_IDLE : (seen_bg_n && seen_h_n) ? J_DECIDE : J_COLLECT;
      J_DECIDE:  nx = J_DONE;
      J_DONE:    nx = J_WAIT;
      J_WAIT:    nx = in_judge ? J_WAIT : J_IDLE;
      default:   nx = J_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      score_bg <= '0;
      score_h <= '0;
      seen_bg <= 1'b0;
      seen_h <= 1'b0;
      Judge_done <= 1'b0;
      Judge_all_done <= 1'b0;
      human_detected <= 1'b0;
      alarm <= 1'b0;
      frame_count <= '0;
      consec_count <= '0;
    end else begin
      Judge_done <= 1'b0;
      Judge_all_done <= 1'b0;
      if (st == J_IDLE && in_judge) begin
        seen_bg <= 1'b0;
        seen_h <= 1'b0;
      end
      if (beat && fc_class_idx) begin
        score_h <= fc_score;
        seen_h <= 1'b1;
      end
      if (beat && !fc_class_idx) begin
        score_bg <= fc_score;
        seen_bg <= 1'b1;
      end
      if (st == J_DECIDE) begin
        human_detected <= verdict;
        consec_count <= consec_n;
        alarm <= consec_n >= 4'(ALARM_THRESHOLD);
        frame_count <= last ? 8'd0 : frame_count + 8'd1;
        Judge_done <= !last;
        Judge_all_done <= last;
      end
    end
  end
endmodule

// File: tb/tb_judge_unit.sv
// tb_judge_unit: directed and randomized frames checked against a frame-level reference model
module tb_judge_unit;
  localparam int FPR = 8;
  localparam int THR = 3;
  localparam int MRG = 0;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] state = 4'd0;
  logic fc_valid = 1'b0;
  logic fc_class_idx = 1'b0;
  logic [15:0] fc_score = '0;
  logic Judge_done, Judge_all_done, human_detected, alarm;
  logic [7:0] frame_count;
  logic [3:0] consec_count;
  int vectors = 0;
  int miscompares = 0;
  int m_consec, m_frame;
  bit m_alarm, m_hd;

  judge_unit #(
    .STATE_DATAWIDTH(4), .JUDGE_STATE(12), .SCORE_WIDTH(16), .MARGIN(16'(MRG)),
    .FRAMES_PER_RUN(FPR), .ALARM_THRESHOLD(THR)
  ) dut (
    .clk(clk), .reset(reset), .state(state), .fc_valid(fc_valid),
    .fc_class_idx(fc_class_idx), .fc_score(fc_score), .Judge_done(Judge_done),
    .Judge_all_done(Judge_all_done), .human_detected(human_detected), .alarm(alarm),
    .frame_count(frame_count), .consec_count(consec_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulses0(input string tag);
    check({tag, "_done"}, 32'(Judge_done), 32'd0);
    check({tag, "_all_done"}, 32'(Judge_all_done), 32'd0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_human"}, 32'(human_detected), 32'(m_hd));
    check({tag, "_consec"}, 32'(consec_count), 32'(m_consec));
    check({tag, "_frame"}, 32'(frame_count), 32'(m_frame));
    check({tag, "_alarm"}, 32'(alarm), 32'(m_alarm));
  endtask

  task automatic model_reset;
    m_consec = 0;
    m_frame = 0;
    m_alarm = 0;
    m_hd = 0;
  endtask

  task automatic do_reset;
    state = 4'd5;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    model_reset;
  endtask

  task automatic beat(input logic c, input logic [15:0] s);
    fc_valid = 1'b1;
    fc_class_idx = c;
    fc_score = s;
    tick;
    fc_valid = 1'b0;
  endtask

  task automatic enter;
    state = 4'd12;
    tick;
  endtask

  task automatic leave;
    state = 4'd5;
    tick;
  endtask

  // Called in the cycle after the final beat edge; walks through the decision, the pulse and the wait cycle
  task automatic judge(input string tag, input logic signed [15:0] h, input logic signed [15:0] bg);
    bit fin;
    pulses0({tag, "_decide"});
    tick;
    m_hd = int'(h) > int'(bg) + MRG;
    m_consec = m_hd ? (m_consec >= 15 ? 15 : m_consec + 1) : 0;
    m_alarm = m_consec >= THR;
    m_frame++;
    fin = m_frame == FPR;
    if (fin) m_frame = 0;
    check_state(tag);
    check({tag, "_done"}, 32'(Judge_done), 32'(!fin));
    check({tag, "_all_done"}, 32'(Judge_all_done), 32'(fin));
    tick;
    pulses0({tag, "_wait"});
  endtask

  task automatic full_frame(input string tag, input logic signed [15:0] h, input logic signed [15:0] bg, input bit h_first);
    enter;
    if (h_first) begin
      beat(1'b1, h);
      beat(1'b0, bg);
    end else begin
      beat(1'b0, bg);
      beat(1'b1, h);
    end
    judge(tag, h, bg);
    leave;
  endtask

  initial begin
    model_reset;
    tick;
    tick;
    check_state("reset");
    pulses0("reset");
    reset = 1'b1;
    state = 4'd5;
    tick;
    full_frame("basic", 16'sd300, 16'sd100, 1'b0);

    do_reset;
    for (int i = 0; i < 3; i++) full_frame("streak", 16'sd500, -16'sd20, 1'b1);
    check("alarm_at_third", 32'(alarm), 32'd1);
    full_frame("bg_clears", -16'sd500, 16'sd10, 1'b0);
    check("alarm_cleared", 32'(alarm), 32'd0);

    do_reset;
    for (int i = 0; i < FPR; i++) full_frame("run8", 16'sd1, 16'sd2, i[0]);
    check("run8_wrap", 32'(frame_count), 32'd0);

    enter;
    beat(1'b1, 16'sd50);
    beat(1'b1, -16'sd50);
    beat(1'b0, 16'sd0);
    judge("dup_last_wins", -16'sd50, 16'sd0);
    leave;

    state = 4'd5;
    fc_valid = 1'b1;
    fc_class_idx = 1'b1;
    fc_score = 16'sd30000;
    for (int i = 0; i < 3; i++) begin
      tick;
      pulses0("idle_beat");
    end
    fc_valid = 1'b0;
    check_state("idle_beat");

    enter;
    beat(1'b0, 16'sd7);
    state = 4'd5;
    tick;
    pulses0("abort");
    tick;
    pulses0("abort2");
    check_state("abort");
    enter;
    beat(1'b0, 16'sd0);
    beat(1'b1, 16'sd1);
    judge("after_abort", 16'sd1, 16'sd0);
    for (int i = 0; i < 5; i++) begin
      tick;
      pulses0("hold_wait");
    end
    leave;

    enter;
    beat(1'b0, 16'sd5);
    beat(1'b1, 16'sd9);
    reset = 1'b0;
    tick;
    model_reset;
    check_state("reset_decide");
    pulses0("reset_decide");
    reset = 1'b1;
    state = 4'd5;
    tick;
    pulses0("post_reset");
    full_frame("after_reset", 16'sd9, 16'sd5, 1'b1);

    full_frame("signed_edge", 16'sh8000, 16'sh7FFF, 1'b0);
    check("signed_edge_verdict", 32'(human_detected), 32'd0);

    for (int i = 0; i < 24; i++) begin
      logic signed [15:0] h, bg;
      h = 16'($urandom);
      bg = (i % 5 == 0) ? h : 16'($urandom);
      if (i % 7 == 3) h = 16'sh7FFF;
      if (i % 7 == 4) bg = 16'sh8000;
      full_frame("rand", h, bg, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
